imm_encoder: RTL
================

IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-002 SHALL have port rst, input, 1 bit: the only reset, asynchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: an encode request is present.
REQ-004 SHALL have port in_ready, output, 1 bit: the block accepts the request this cycle.
REQ-005 SHALL have port fmt, input, 3 bits: the instruction format, R=0, I=1, S=2, B=3, U=4, J=5; values 6 and 7 are illegal.
REQ-006 SHALL have ports opcode (7 bits), rd (5), rs1 (5), rs2 (5), funct3 (3) and funct7 (7), all inputs, holding the raw fields.
REQ-007 SHALL have port imm, input, 32 bits: the full byte-offset or value immediate.
REQ-008 SHALL have port out_valid, output, 1 bit: an encoded instruction is available.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the output.
REQ-010 SHALL have port insn, output, 32 bits: the encoded RV32 instruction word.
REQ-011 SHALL have port err, output, 1 bit: the immediate is not representable or fmt is illegal.
REQ-012 SHALL have port err_count, output, 8 bits: a saturating count of delivered words with err set.

Function
REQ-013 SHALL place opcode at insn[6:0] in every format; rd at [11:7] for R/I/U/J; funct3 at [14:12] for R/I/S/B; rs1 at [19:15] for R/I/S/B; rs2 at [24:20] for R/S/B; funct7 at [31:25] for R only.
REQ-014 SHALL pack the immediate by format:
  - I: imm[11:0] to insn[31:20].
  - S: imm[11:5] to [31:25] and imm[4:0] to [11:7].
  - B: imm[12] to [31], imm[10:5] to [30:25], imm[4:1] to [11:8], imm[11] to [7].
  - U: imm[31:12] to [31:12].
  - J: imm[20] to [31], imm[10:1] to [30:21], imm[11] to [20], imm[19:12] to [19:12].
  - R: the immediate is ignored.
REQ-015 SHALL flag err under these rules:
  - I and S: imm is outside the signed 12-bit range.
  - B: imm is outside the signed 13-bit range or imm[0]=1.
  - J: imm is outside the signed 21-bit range or imm[0]=1.
  - U: imm[11:0] is not 0.
  - Any format: fmt is 6 or 7, in which case insn SHALL be 0.
REQ-016 SHALL form a 2-stage pipeline: stage 1 registers the fields together with the range check, and stage 2 registers insn and err; out_valid SHALL assert 2 cycles after an accepted request when the output is not stalled.
REQ-017 SHALL make a transfer on in_valid&&in_ready, and likewise on out_valid&&out_ready.
REQ-018 SHALL hold insn and err stable while out_valid=1 and out_ready=0.
REQ-019 SHALL compute in_ready = !s1_valid || !s2_valid || out_ready, giving full throughput (1 word per cycle) with no bubbles and no drops under backpressure.
REQ-020 SHALL increment err_count on each output transfer that has err=1, saturating at 255 with no wrap.
REQ-021 SHALL let simultaneous input and output transfers in one cycle both complete, with stage contents advancing in order.

Reset
REQ-022 SHALL, while rst=1, clear the stage valids so that out_valid=0, in_ready=1 after reset, insn=0, err=0 and err_count=0.
REQ-023 SHALL discard in-flight words when rst asserts mid-operation, with nothing delivered after reset releases.

Configuration
REQ-024 SHALL, when IMMENC_RANGE_CHECK_EN is defined, implement the REQ-015 checks and err_count.
REQ-025 SHALL, when IMMENC_RANGE_CHECK_EN is undefined:
  - tie err and err_count to 0;
  - encode illegal fmt values as R;
  - silently truncate out-of-range immediates;
  - leave pipeline timing unchanged.

Structure
REQ-026 SHALL place the fmt enum constants and opcode constants (OP_IMM=0x13, LUI=0x37, JAL=0x6F, BRANCH=0x63, STORE=0x23) in the shared package rv_pkg.
REQ-027 SHALL put the combinational packing of REQ-013/014 in the sub-module imm_pack; range checking and pipeline control SHALL stay in imm_encoder.

Verification
REQ-028 SHALL cover: fmt=I, opcode=0x13, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF -> insn=0xFFF00093, err=0.
REQ-029 SHALL cover: fmt=B, opcode=0x63, rs1=1, rs2=2, funct3=0, imm=0xFFFFFFFC -> insn=0xFE208EE3, err=0.
REQ-030 SHALL cover: fmt=J, opcode=0x6F, rd=1, imm=0x800 -> insn=0x001000EF; the same request with fmt=U, opcode=0x37, rd=5, imm=0x12345000 -> insn=0x123452B7.
REQ-031 SHALL cover: fmt=B with imm=3, then fmt=I with imm=2048, then fmt=7 -> err=1 on each; err_count=3; the fmt=7 word has insn=0.
REQ-032 SHALL cover: 10 back-to-back requests with out_ready held 0 for 5 cycles -> in_ready drops after 2 accepted, all 10 words delivered in order unchanged, and throughput returns to 1/cycle once out_ready=1.
REQ-033 SHALL cover: rst asserted while 2 words are in flight -> out_valid=0 immediately, no stale word after release, err_count=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32 encoding definitions: instruction formats, opcodes, encoder request bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_STORE  = 7'h23;

    // Raw fields of one encode request, carried through stage 1
    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } enc_req_t;

    // Codes 6 and 7 do not name a format
    function automatic logic fmt_legal(input logic [2:0] f);
        return f <= FMT_J;
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Places RV32 register fields and the format-specific immediate slices into an instruction word.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the enclosing pipeline stage decides when the result is captured.
module imm_pack
    import rv_pkg::*;
(
    input  enc_req_t    req,
    output logic [31:0] insn
);

    // Select bit placement by format; unknown formats produce an all-zero word
    always_comb begin
        insn = 32'd0;
        case (req.fmt)
            FMT_R: insn = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
            FMT_I: insn = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
            FMT_S: insn = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
            FMT_B: insn = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                           req.imm[4:1], req.imm[11], req.opcode};
            FMT_U: insn = {req.imm[31:12], req.rd, req.opcode};
            FMT_J: insn = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                           req.rd, req.opcode};
            default: insn = 32'd0;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// RV32 instruction encoder: fields + immediate in, packed word (+ range error) out. Option macro: IMMENC_RANGE_CHECK_EN.
// Latency: 2 cycles from accepted request to out_valid; 1 word/cycle sustained.
// Backpressure: valid/ready both sides; stages hold under out_ready=0, in_ready drops only when both stages are full.
module imm_encoder
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] insn,
    output logic        err,
    output logic [7:0]  err_count
);

    enc_req_t    in_req;
    enc_req_t    s1_req;
    logic        s1_valid;
    logic        s2_valid;
    logic        s2_adv;
    logic [31:0] pack_insn;

    // Stage 2 may load whenever it is empty or its word leaves this cycle;
    // stage 1 may load whenever it is empty or it can hand its word to stage 2
    assign s2_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || !s2_valid || out_ready;
    assign out_valid = s2_valid;

    // Gather raw fields; without the checker an illegal format is encoded as R
    always_comb begin
        in_req = '{fmt: fmt, opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                   funct3: funct3, funct7: funct7, imm: imm};
`ifndef IMMENC_RANGE_CHECK_EN
        if (!fmt_legal(fmt)) in_req.fmt = FMT_R;
`endif
    end

    // Stage 1: capture the request fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_req   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) s1_req <= in_req;
        end
    end

    imm_pack u_pack (
        .req  (s1_req),
        .insn (pack_insn)
    );

    // Stage 2: capture the packed word; it stays put while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            insn     <= 32'd0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) insn <= pack_insn;
        end
    end

`ifdef IMMENC_RANGE_CHECK_EN
    logic in_err;
    logic s1_err;

    // Representability check on the raw immediate (sign bits above the field must all match)
    always_comb begin
        in_err = 1'b0;
        case (fmt)
            FMT_R:        in_err = 1'b0;
            FMT_I, FMT_S: in_err = imm[31:11] != {21{imm[31]}};
            FMT_B:        in_err = (imm[31:12] != {20{imm[31]}}) || imm[0];
            FMT_U:        in_err = imm[11:0] != 12'd0;
            FMT_J:        in_err = (imm[31:20] != {12{imm[31]}}) || imm[0];
            default:      in_err = 1'b1;
        endcase
    end

    // Stage 1 error flag travels alongside the fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        s1_err <= 1'b0;
        else if (in_ready && in_valid)  s1_err <= in_err;
    end

    // Stage 2 error flag travels alongside the packed word
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        err <= 1'b0;
        else if (s2_adv && s1_valid)    err <= s1_err;
    end

    // Count delivered words that carry err, sticking at 255
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_count <= 8'd0;
        else if (out_valid && out_ready && err && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
    end
`else
    assign err       = 1'b0;
    assign err_count = 8'd0;
`endif

endmodule
